// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: takes a PC, runs one single-beat read on the imem bus,
// and hands the word plus its PC to the decoder. One fetch in flight; flush-safe.
module ifu_fetch #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     pc,
  input  logic                 pc_valid,
  output logic                 pc_ready,
  input  logic                 flush,
  output logic                 mem_req_valid,
  output logic [WIDTH-1:0]     mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [WIDTH-1:0]     mem_rsp_data,
  input  logic                 mem_rsp_err,
  output logic                 inst_valid,
  output logic [WIDTH-1:0]     inst,
  output logic [WIDTH-1:0]     inst_pc,
  output logic                 inst_err,
  input  logic                 inst_ready,
  output logic [CNT_WIDTH-1:0] fetch_cnt
);

  // state | meaning
  // IDLE  | nothing in flight, ready for a PC
  // REQ   | read request presented, waiting for mem_req_ready
  // WAIT  | request accepted, waiting for the response
  // HOLD  | instruction presented to the decoder
  // DROP  | flushed fetch; swallow the stale response
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t               state_q, state_d;
  logic                 kill_q, kill_d;
  logic                 req_valid_q, req_valid_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [WIDTH-1:0]     inst_q, inst_d;
  logic [WIDTH-1:0]     inst_pc_q, inst_pc_d;
  logic                 inst_err_q, inst_err_d;
  logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
  logic                 accept;

  assign pc_ready = !flush && ((state_q == IDLE) || ((state_q == HOLD) && inst_ready));
  assign accept   = pc_valid && pc_ready;

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    req_valid_d  = req_valid_q;
    addr_d       = addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_err_d   = inst_err_q;
    fetch_cnt_d  = fetch_cnt_q;

    case (state_q)
      IDLE: ;
      REQ: begin
        // The request stays on the bus even when flushed; kill marks it stale.
        if (flush) kill_d = 1'b1;
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = (kill_q || flush) ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            inst_d       = mem_rsp_data;
            inst_err_d   = mem_rsp_err;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (flush) begin
          kill_d  = 1'b1;
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_rsp_valid) begin
          kill_d  = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (inst_ready) begin
          fetch_cnt_d  = fetch_cnt_q + CNT_WIDTH'(1);
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance only happens from IDLE or a consumed HOLD, so it overrides the above.
    if (accept) begin
      addr_d    = pc;
      inst_pc_d = pc;
      if (pc[1:0] == 2'b00) begin
        req_valid_d  = 1'b1;
        inst_valid_d = 1'b0;
        state_d      = REQ;
      end else begin
        inst_d       = '0;
        inst_err_d   = 1'b1;
        inst_valid_d = 1'b1;
        state_d      = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      addr_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_err_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = addr_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_err      = inst_err_q;
  assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst, pc_valid, flush, mem_req_ready, mem_rsp_valid, mem_rsp_err, inst_ready;
  logic [31:0] pc, mem_rsp_data;
  logic        pc_ready, mem_req_valid, inst_valid, inst_err;
  logic [31:0] mem_req_addr, inst, inst_pc, fetch_cnt;

  ifu_fetch #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_ready(inst_ready), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus for the next cycle
  logic        s_rst, s_pc_valid, s_flush, s_req_ready, s_rsp_valid, s_rsp_err, s_inst_ready;
  logic [31:0] s_pc, s_rsp_data;

  // model: a request on the bus, a response owed, whether that response is dead,
  // and the instruction currently offered to the decoder
  logic        m_live = 1'b0;
  logic        m_req, m_wait, m_doom, m_hold, m_err;
  logic [31:0] m_pc, m_inst, m_cnt;

  // memory responder bookkeeping
  logic        mem_out = 1'b0;
  int          mem_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_stim();
    s_rst = 0; s_pc_valid = 0; s_pc = 0; s_flush = 0; s_req_ready = 0;
    s_rsp_valid = 0; s_rsp_data = 0; s_rsp_err = 0; s_inst_ready = 0;
  endtask

  task automatic model_step(input logic rdy);
    logic acc;
    acc = s_pc_valid && rdy;
    if (s_rst) begin
      m_req = 0; m_wait = 0; m_doom = 0; m_hold = 0; m_err = 0;
      m_pc = 0; m_inst = 0; m_cnt = 0; m_live = 1;
      return;
    end
    if (m_hold && s_inst_ready && !s_flush) m_cnt = m_cnt + 1;
    if (m_hold && (s_flush || s_inst_ready)) m_hold = 0;
    if (m_req) begin
      if (s_flush) m_doom = 1;
      if (s_req_ready) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (s_rsp_valid) begin
        if (!m_doom && !s_flush) begin m_hold = 1; m_inst = s_rsp_data; m_err = s_rsp_err; end
        m_wait = 0; m_doom = 0;
      end else if (s_flush) begin
        m_doom = 1;
      end
    end
    if (acc) begin
      m_pc = s_pc;
      if (s_pc[1:0] == 2'b00) m_req = 1;
      else begin m_hold = 1; m_inst = 0; m_err = 1; end
    end
  endtask

  task automatic tick();
    logic exp_rdy;
    @(negedge clk);
    rst = s_rst; pc_valid = s_pc_valid; pc = s_pc; flush = s_flush;
    mem_req_ready = s_req_ready; mem_rsp_valid = s_rsp_valid;
    mem_rsp_data = s_rsp_data; mem_rsp_err = s_rsp_err; inst_ready = s_inst_ready;
    #1;
    exp_rdy = !s_flush && !m_req && !m_wait && (!m_hold || s_inst_ready);
    if (m_live) begin
      chk("pc_ready", {31'b0, pc_ready}, {31'b0, exp_rdy});
      chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, m_req});
      chk("mem_req_addr", mem_req_addr, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_pc);
      chk("inst_err", {31'b0, inst_err}, {31'b0, m_err});
      chk("fetch_cnt", fetch_cnt, m_cnt);
    end
    if (mem_req_valid && s_req_ready) begin
      mem_out = 1;
      mem_dly = s_rst ? 0 : int'($urandom_range(0, 2));
    end
    model_step(exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stim();
    s_rst        = ($urandom_range(0, 199) == 0);
    s_pc_valid   = ($urandom_range(0, 9) < 6);
    s_pc         = 32'h8000_0000 | ($urandom_range(0, 255) << 2);
    if ($urandom_range(0, 7) == 0) s_pc[1:0] = 2'($urandom_range(1, 3));
    s_flush      = ($urandom_range(0, 11) == 0);
    s_req_ready  = $urandom_range(0, 1) == 1;
    s_inst_ready = $urandom_range(0, 1) == 1;
    s_rsp_valid  = 0;
    s_rsp_data   = $urandom;
    s_rsp_err    = 0;
    if (mem_out) begin
      if (mem_dly == 0 || s_rst) begin
        s_rsp_valid = 1;
        s_rsp_err   = ($urandom_range(0, 7) == 0);
        mem_out     = 0;
      end else begin
        mem_dly--;
      end
    end
  endtask

  initial begin
    idle_stim();
    s_rst = 1; tick(); tick();
    s_rst = 0;
    chk("rst_pc_ready", {31'b0, pc_ready}, 32'd1);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);

    // zero-wait fetch
    s_inst_ready = 1; s_req_ready = 1;
    s_pc_valid = 1; s_pc = 32'h8000_0000; tick();
    s_pc_valid = 0; tick();
    chk("t1_not_early", {31'b0, inst_valid}, 32'd0);
    s_rsp_valid = 1; s_rsp_data = 32'h0000_0413; tick();
    s_rsp_valid = 0;
    chk("t1_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_pc", inst_pc, 32'h8000_0000);
    chk("t1_err", {31'b0, inst_err}, 32'd0);
    tick();
    chk("t1_cnt", fetch_cnt, 32'd1);

    // backpressure on both sides
    idle_stim();
    s_pc_valid = 1; s_pc = 32'h8000_0020; tick();
    s_pc_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_req_hold", {31'b0, mem_req_valid}, 32'd1);
      chk("t2_addr_hold", mem_req_addr, 32'h8000_0020);
    end
    s_req_ready = 1; tick();
    s_req_ready = 0; s_rsp_valid = 1; s_rsp_data = 32'h0040_0513; tick();
    s_rsp_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_inst_hold", inst, 32'h0040_0513);
    end
    chk("t2_cnt_before", fetch_cnt, 32'd1);
    s_inst_ready = 1; tick();
    s_inst_ready = 0;
    chk("t2_cnt", fetch_cnt, 32'd2);

    // misaligned pc
    s_pc_valid = 1; s_pc = 32'h8000_0002; tick();
    s_pc_valid = 0;
    chk("t3_no_req", {31'b0, mem_req_valid}, 32'd0);
    chk("t3_valid", {31'b0, inst_valid}, 32'd1);
    chk("t3_err", {31'b0, inst_err}, 32'd1);
    chk("t3_inst", inst, 32'd0);
    chk("t3_pc", inst_pc, 32'h8000_0002);
    s_inst_ready = 1; tick();
    s_inst_ready = 0;
    chk("t3_cnt", fetch_cnt, 32'd3);

    // flush in WAIT, stale response dropped
    s_pc_valid = 1; s_pc = 32'h8000_0008; tick();
    s_pc_valid = 0; s_req_ready = 1; tick();
    s_req_ready = 0; s_flush = 1; tick();
    s_flush = 0; s_pc_valid = 1; s_pc = 32'h8000_0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_pc_ready_low", {31'b0, pc_ready}, 32'd0);
    end
    s_rsp_valid = 1; s_rsp_data = 32'hDEAD_BEEF; tick();
    s_rsp_valid = 0;
    chk("t4_dropped_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_dropped_inst", inst, 32'd0);
    tick();
    s_pc_valid = 0; s_req_ready = 1; tick();
    s_req_ready = 0; s_rsp_valid = 1; s_rsp_data = 32'h0010_0093; tick();
    s_rsp_valid = 0;
    chk("t4_inst", inst, 32'h0010_0093);
    chk("t4_pc", inst_pc, 32'h8000_0010);
    s_inst_ready = 1; tick();
    s_inst_ready = 0;
    chk("t4_cnt", fetch_cnt, 32'd4);

    // back-to-back accept from HOLD, then a bus error
    s_pc_valid = 1; s_pc = 32'h8000_0030; tick();
    s_pc_valid = 0; s_req_ready = 1; tick();
    s_req_ready = 0; s_rsp_valid = 1; s_rsp_data = 32'h0000_0013; tick();
    s_rsp_valid = 0;
    s_inst_ready = 1; s_pc_valid = 1; s_pc = 32'h8000_0004; tick();
    s_inst_ready = 0; s_pc_valid = 0;
    chk("t5_b2b_req", {31'b0, mem_req_valid}, 32'd1);
    chk("t5_b2b_addr", mem_req_addr, 32'h8000_0004);
    chk("t5_cnt_a", fetch_cnt, 32'd5);
    s_req_ready = 1; tick();
    s_req_ready = 0; s_rsp_valid = 1; s_rsp_err = 1; s_rsp_data = 32'h1234_5678; tick();
    s_rsp_valid = 0; s_rsp_err = 0;
    chk("t5_err", {31'b0, inst_err}, 32'd1);
    chk("t5_err_pc", inst_pc, 32'h8000_0004);
    s_inst_ready = 1; tick();
    s_inst_ready = 0;
    chk("t5_cnt_b", fetch_cnt, 32'd6);

    // reset in REQ, then in WAIT with a late response
    s_pc_valid = 1; s_pc = 32'h8000_0040; tick();
    s_pc_valid = 0; tick();
    s_rst = 1; tick();
    s_rst = 0;
    chk("t6_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("t6_addr", mem_req_addr, 32'd0);
    chk("t6_inst_pc", inst_pc, 32'd0);
    chk("t6_err", {31'b0, inst_err}, 32'd0);
    chk("t6_cnt", fetch_cnt, 32'd0);
    s_pc_valid = 1; s_pc = 32'h8000_0044; tick();
    s_pc_valid = 0; s_req_ready = 1; tick();
    s_req_ready = 0; s_rst = 1; tick();
    s_rst = 0;
    chk("t6_wait_valid", {31'b0, inst_valid}, 32'd0);
    s_rsp_valid = 1; s_rsp_data = 32'hBAD0_BAD0; tick();
    s_rsp_valid = 0;
    tick();
    chk("t6_late_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_late_inst", inst, 32'd0);

    // random traffic against the model
    idle_stim();
    s_rst = 1; tick();
    mem_out = 0;
    for (int i = 0; i < 4000; i++) begin
      rand_stim();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
